bfp_decomp_expand: RTL and testbench
====================================

# bfp_decomp_expand

Consumes the unpacked bit chunks produced by the BFP decompression gearbox and expands them into 16-bit I/Q samples, two REs (four samples) per cycle. It sits directly downstream of the gearbox and upstream of the RE mapper/stream FIFO in the O-RAN U-plane receive path. For each resource block it captures the block exponent, sign-extends each mantissa, shifts it left by the exponent, and saturates the result to 16 bits. Uncompressed streams pass through unchanged.

## Interface

- `SAT_EN`, default 1: 1 = saturate to the 16-bit signed range; 0 = keep the low 16 bits (wrap).

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `din_width`  in  4  udIqWidth in bits, 1..15; 0 = uncompressed, 16-bit samples, no exponent field.
- `din_data`  in  64  bit chunk, right-aligned (LSB); layout defined under Operation.
- `din_valid`  in  1  chunk valid; no backpressure.
- `din_last`  in  1  final chunk of the section/packet.
- `din_user`  in  32  section metadata, passed through unchanged.
- `m_axis_tdata`  out  64  {I0,Q0,I1,Q1}, 16 bits each, I0 in [63:48].
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tlast`  out  1  aligned with the last output word.
- `m_axis_tuser`  out  32  delayed `din_user`.
- `err_saturate`  out  1  one-cycle pulse; at least one sample in the word was clipped.
- `err_short_rb`  out  1  one-cycle pulse; `din_last` arrived with `rb_idx` != 5.

## Operation

**Chunk layout** (w = `din_width`, w != 0)
- Tick with `rb_idx` = 0: chunk is 4w+8 bits.
  - `udCompParam` byte at [4w+7:4w]; exponent = [4w+3:4w]; the upper nibble is ignored.
  - Sample k (k = 0..3) at [w(4-k)-1 : w(3-k)].
- Ticks with `rb_idx` = 1..5: 4w bits, same sample positions, no exponent.

**Uncompressed** (w = 0)
- Sample k at [16(4-k)-1 : 16(3-k)], copied unchanged.
- Exponent forced to 0, `err_saturate` never asserted.

**RB counter `rb_idx`** (0..5, one RB = 12 REs = 6 ticks)
- Advances on each `din_valid`.
- Wraps 5 -> 0.
- Forced to 0 after any `din_valid && din_last`.
- Held while `din_valid` = 0.

**Exponent register**
- Loaded on `din_valid && rb_idx == 0 && w != 0`.
- Samples on the `rb_idx` = 0 tick use the freshly extracted exponent (bypass), not the stale register value.

**Per-sample arithmetic**
- Sign-extend the w-bit mantissa to 31 bits.
- Shift left by exp (0..15).
- If SAT_EN = 1: clip to [-32768, 32767].
- If SAT_EN = 0: take bits [15:0].

**Errors**
- `err_short_rb` pulses when `din_valid && din_last && rb_idx != 5 && w != 0`. The counter still resets to 0.
- `err_saturate` pulses with the affected output word.

## Timing

- Two-stage pipeline: `din_*` -> `m_axis_*` latency is exactly 2 cycles.
  - Stage 1 registers the extracted fields, exponent and sideband.
  - Stage 2 registers shift/saturate results.
- `m_axis_tvalid`, `tlast`, `tuser` and `err_saturate` stay cycle-aligned with `tdata`.
- `err_short_rb` is issued 2 cycles after the offending input.
- One output word for every `din_valid`; no bubbles are inserted or removed. Throughput is 1 word/cycle.
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `err_*` = 0.
  - `m_axis_tdata`, `m_axis_tuser` = 0.
  - `rb_idx` = 0, exponent = 0.
- Reset mid-packet: the pipeline is flushed; no output valid for 2 cycles after reset deasserts unless new input arrives.
- `din_width` is sampled every valid cycle; the upstream block holds it constant within a packet.

## Structure

- Shared `oran_pkg` additions:
  - `UD_COMP_METH_BFP` = 4'b0001
  - `TICKS_PER_RB` = 6
  - `IQ_W` = 16
  - function `sat16` (signed 31-bit -> 16-bit clip)
- Sub-module `bfp_decomp_sample`: one mantissa in plus width and exponent -> 16-bit sample and a sat flag. It is combinational, instantiated 4x; the top level owns the registers.
- The top level holds `rb_idx`, the exponent register, the field mux and the pipeline.

## Test plan

- w=9, exp=3, all samples 0x0FF -> every output sample 0x07F8; `err_saturate` = 0; latency 2.
- w=9, exp=3, sample 0x100 (-256) -> 0xF800; mixed signs verified per lane.
- w=9, exp=8, sample 0x0FF -> 0x7FFF with `err_saturate` = 1. With SAT_EN=0 -> 0xFF00 and no flag.
- w=0, 0x0123_4567_89AB_CDEF x6 with `din_last` on 6th -> identical words out, `tlast` on 6th, `tuser` preserved.
- Two RBs, exp 2 then exp 5, `din_last` on tick 12 -> exponent switches exactly at output word 7; no `err_short_rb`.
- `din_last` at `rb_idx`=2 -> `err_short_rb` pulse; the next `din_valid` is parsed as an exponent tick. Also assert `rst` mid-RB -> outputs 0, `rb_idx` restarts at 0.

Source files
------------

// File: rtl/oran_pkg.sv
// Shared O-RAN U-plane constants and helpers used by the BFP decompression path.
package oran_pkg;

  localparam logic [3:0]  UD_COMP_METH_BFP = 4'b0001;
  localparam int unsigned TICKS_PER_RB     = 6;
  localparam int unsigned IQ_W             = 16;
  localparam int unsigned RB_IDX_W         = 3;

  typedef logic [IQ_W-1:0]     iq_t;
  typedef logic [RB_IDX_W-1:0] rb_idx_t;

  // Clip a signed 31-bit intermediate to the 16-bit signed range.
  function automatic iq_t sat16(input logic signed [30:0] v);
    if (v > 31'sd32767) begin
      return 16'h7FFF;
    end else if (v < -31'sd32768) begin
      return 16'h8000;
    end else begin
      return v[15:0];
    end
  endfunction

  // True when sat16() would alter the value.
  function automatic logic is_clip16(input logic signed [30:0] v);
    return (v > 31'sd32767) || (v < -31'sd32768);
  endfunction

endpackage

// File: rtl/bfp_decomp_expand_sample.sv
// One BFP lane: sign-extend a w-bit mantissa, shift by the block exponent,
// then saturate (or wrap) to 16 bits. Width 0 passes the raw 16 bits through.
module bfp_decomp_sample
  import oran_pkg::*;
#(
  parameter bit SAT_EN = 1'b1
) (
  input  logic [15:0] mant,
  input  logic [3:0]  width,
  input  logic [3:0]  exp,
  output iq_t         sample,
  output logic        sat
);

  localparam logic [30:0] ONES31 = '1;

  logic [30:0]        low_mask;
  logic [30:0]        ext;
  logic               sign_bit;
  logic signed [30:0] shifted;

  // Sign-extend, shift and clip one mantissa.
  always_comb begin
    low_mask = ~(ONES31 << width);
    ext      = {15'b0, mant} & low_mask;
    sign_bit = 1'b0;
    if (width != 4'd0) begin
      sign_bit = mant[width - 4'd1];
    end
    if (sign_bit) begin
      ext = ext | ~low_mask;
    end
    shifted = $signed(ext) <<< exp;

    sample = mant;
    sat    = 1'b0;
    if (width != 4'd0) begin
      if (SAT_EN) begin
        sample = sat16(shifted);
        sat    = is_clip16(shifted);
      end else begin
        sample = shifted[15:0];
      end
    end
  end

endmodule

// File: rtl/bfp_decomp_expand.sv
// BFP decompression expander: parses gearbox chunks into four mantissas plus
// the per-RB exponent, then expands them to 16-bit I/Q in a 2-stage pipeline.
module bfp_decomp_expand
  import oran_pkg::*;
#(
  parameter bit SAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  din_width,
  input  logic [63:0] din_data,
  input  logic        din_valid,
  input  logic        din_last,
  input  logic [31:0] din_user,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic [31:0] m_axis_tuser,
  output logic        err_saturate,
  output logic        err_short_rb
);

  rb_idx_t     rb_idx;
  logic [3:0]  exp_reg;

  logic [4:0]  stride;
  logic [6:0]  field_sh [4];
  logic [15:0] field    [4];
  logic [3:0]  exp_field;
  logic [3:0]  exp_cur;
  logic        short_rb;

  logic        s1_valid;
  logic        s1_last;
  logic        s1_short;
  logic [31:0] s1_user;
  logic [3:0]  s1_width;
  logic [3:0]  s1_exp;
  logic [15:0] s1_mant  [4];

  iq_t         smp      [4];
  logic [3:0]  sat;

  // Field mux: samples sit at the same positions on every tick, so only the
  // stride differs between compressed and uncompressed chunks.
  always_comb begin
    stride = (din_width == 4'd0) ? 5'd16 : {1'b0, din_width};
    for (int unsigned k = 0; k < 4; k++) begin
      field_sh[k] = 7'({2'b00, stride} * 7'(3 - k));
      field[k]    = 16'(din_data >> field_sh[k]);
    end
    exp_field = 4'(din_data >> {din_width, 2'b00});
    if (din_width == 4'd0) begin
      exp_cur = 4'd0;
    end else if (rb_idx == '0) begin
      exp_cur = exp_field;
    end else begin
      exp_cur = exp_reg;
    end
    short_rb = din_valid && din_last && (rb_idx != rb_idx_t'(TICKS_PER_RB - 1))
               && (din_width != 4'd0);
  end

  // RB tick counter and held block exponent.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_idx  <= '0;
      exp_reg <= '0;
    end else if (din_valid) begin
      if (rb_idx == '0 && din_width != 4'd0) begin
        exp_reg <= exp_field;
      end
      if (din_last || rb_idx == rb_idx_t'(TICKS_PER_RB - 1)) begin
        rb_idx <= '0;
      end else begin
        rb_idx <= rb_idx + 1'b1;
      end
    end
  end

  // Stage 1: register extracted fields, effective exponent and sideband.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_short <= 1'b0;
      s1_user  <= '0;
      s1_width <= '0;
      s1_exp   <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        s1_mant[k] <= '0;
      end
    end else begin
      s1_valid <= din_valid;
      s1_last  <= din_valid && din_last;
      s1_short <= short_rb;
      s1_user  <= din_user;
      s1_width <= din_width;
      s1_exp   <= exp_cur;
      for (int unsigned k = 0; k < 4; k++) begin
        s1_mant[k] <= field[k];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    bfp_decomp_sample #(.SAT_EN(SAT_EN)) u_sample (
      .mant   (s1_mant[g]),
      .width  (s1_width),
      .exp    (s1_exp),
      .sample (smp[g]),
      .sat    (sat[g])
    );
  end

  // Stage 2: register expanded samples and aligned status.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      err_saturate  <= 1'b0;
      err_short_rb  <= 1'b0;
    end else begin
      m_axis_tdata  <= {smp[0], smp[1], smp[2], smp[3]};
      m_axis_tvalid <= s1_valid;
      m_axis_tlast  <= s1_last;
      m_axis_tuser  <= s1_user;
      err_saturate  <= s1_valid && (|sat);
      err_short_rb  <= s1_short;
    end
  end

endmodule

// File: tb/tb_bfp_decomp_expand.sv
// Randomised and directed bench for bfp_decomp_expand with an arithmetic
// reference model; a saturating and a wrapping instance share the stimulus.
module tb_bfp_decomp_expand;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  din_width;
  logic [63:0] din_data;
  logic        din_valid;
  logic        din_last;
  logic [31:0] din_user;

  logic [63:0] td_s, td_w;
  logic        tv_s, tv_w, tl_s, tl_w, es_s, es_w, sr_s, sr_w;
  logic [31:0] tu_s, tu_w;

  always #5 clk = ~clk;

  bfp_decomp_expand #(.SAT_EN(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .din_width(din_width), .din_data(din_data),
    .din_valid(din_valid), .din_last(din_last), .din_user(din_user),
    .m_axis_tdata(td_s), .m_axis_tvalid(tv_s), .m_axis_tlast(tl_s),
    .m_axis_tuser(tu_s), .err_saturate(es_s), .err_short_rb(sr_s)
  );

  bfp_decomp_expand #(.SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .din_width(din_width), .din_data(din_data),
    .din_valid(din_valid), .din_last(din_last), .din_user(din_user),
    .m_axis_tdata(td_w), .m_axis_tvalid(tv_w), .m_axis_tlast(tl_w),
    .m_axis_tuser(tu_w), .err_saturate(es_w), .err_short_rb(sr_w)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic [63:0] d_sat;
    logic [63:0] d_wrap;
    logic        last;
    logic [31:0] user;
    logic        es;
    logic        short_rb;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;
  int   m_rb     = 0;
  int   m_exp    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference arithmetic for one sample, straight from the numeric rules.
  function automatic void model_sample(input longint raw, input int w, input int e,
                                       input bit sat_en, output logic [15:0] s, output bit clip);
    longint m, v;
    clip = 1'b0;
    if (w == 0) begin
      s = raw[15:0];
      return;
    end
    m = raw & ((longint'(1) << w) - 1);
    if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
    v = m * (longint'(1) << e);
    if (sat_en && v > 32767) begin
      s = 16'h7FFF; clip = 1'b1;
    end else if (sat_en && v < -32768) begin
      s = 16'h8000; clip = 1'b1;
    end else begin
      s = v[15:0];
    end
  endfunction

  function automatic logic [63:0] mk(input int w, input bit rb0, input int e,
                                     input int s0, input int s1, input int s2, input int s3);
    logic [63:0] d, mask;
    mask = (64'd1 << w) - 64'd1;
    d = ((64'(s0) & mask) << (3*w)) | ((64'(s1) & mask) << (2*w)) |
        ((64'(s2) & mask) << w) | (64'(s3) & mask);
    if (rb0) d = d | (64'(($urandom & 32'hF0) | (e & 15)) << (4*w));
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int w, input logic [63:0] data, input bit last, input logic [31:0] user);
    exp_t        x;
    int          e, stride;
    logic [15:0] s;
    bit          c;
    longint      raw;
    stride = (w == 0) ? 16 : w;
    if (w != 0 && m_rb == 0) m_exp = int'((data >> (4*w)) & 64'hF);
    e = (w == 0) ? 0 : m_exp;
    x.d_sat = '0; x.d_wrap = '0; x.es = 1'b0;
    for (int k = 0; k < 4; k++) begin
      raw = longint'((data >> (stride*(3-k))) & 64'hFFFF);
      model_sample(raw, w, e, 1'b1, s, c);
      x.d_sat = x.d_sat | (64'(s) << (16*(3-k)));
      x.es = x.es | c;
      model_sample(raw, w, e, 1'b0, s, c);
      x.d_wrap = x.d_wrap | (64'(s) << (16*(3-k)));
    end
    x.last     = last;
    x.user     = user;
    x.short_rb = last && (m_rb != 5) && (w != 0);
    x.due      = cyc + 2;
    m_rb = last ? 0 : (m_rb + 1) % 6;
    q.push_back(x);
    din_width = 4'(w); din_data = data; din_valid = 1'b1;
    din_last = last; din_user = user;
    tick();
    din_valid = 1'b0; din_last = 1'b0;
  endtask

  task automatic do_reset(input int n);
    exp_t keep[$];
    rst = 1'b1; din_valid = 1'b0; din_last = 1'b0;
    foreach (q[i]) if (q[i].due <= cyc) keep.push_back(q[i]);
    q = keep;
    m_rb = 0; m_exp = 0;
    idle(n);
    rst = 1'b0;
  endtask

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        cur = q.pop_front();
        check("tvalid_sat", 64'(tv_s), 64'd1);
        check("tvalid_wrap", 64'(tv_w), 64'd1);
        check("tdata_sat", td_s, cur.d_sat);
        check("tdata_wrap", td_w, cur.d_wrap);
        check("tlast", 64'(tl_s), 64'(cur.last));
        check("tuser", 64'(tu_s), 64'(cur.user));
        check("err_saturate_sat", 64'(es_s), 64'(cur.es));
        check("err_saturate_wrap", 64'(es_w), 64'd0);
        check("err_short_rb", 64'(sr_s), 64'(cur.short_rb));
        check("err_short_rb_wrap", 64'(sr_w), 64'(cur.short_rb));
      end else begin
        check("idle_tvalid", 64'({tv_s, tv_w}), 64'd0);
        check("idle_tlast", 64'({tl_s, tl_w}), 64'd0);
        check("idle_err", 64'({es_s, es_w, sr_s, sr_w}), 64'd0);
      end
    end
  end

  logic [15:0] ps;
  bit          pc;
  int          len, w;

  initial begin
    rst = 1'b1; din_valid = 1'b0; din_last = 1'b0;
    din_width = '0; din_data = '0; din_user = '0;

    // Pin the model against hand-computed values.
    model_sample(64'h0FF, 9, 3, 1'b1, ps, pc);
    check("pin_0ff_e3", 64'(ps), 64'h07F8);
    check("pin_0ff_e3_clip", 64'(pc), 64'd0);
    model_sample(64'h100, 9, 3, 1'b1, ps, pc);
    check("pin_100_e3", 64'(ps), 64'hF800);
    model_sample(64'h0FF, 9, 8, 1'b1, ps, pc);
    check("pin_0ff_e8_sat", 64'({pc, ps}), 64'h1_7FFF);
    model_sample(64'h0FF, 9, 8, 1'b0, ps, pc);
    check("pin_0ff_e8_wrap", 64'({pc, ps}), 64'h0_FF00);
    model_sample(64'h1FF, 9, 3, 1'b1, ps, pc);
    check("pin_neg1_e3", 64'(ps), 64'hFFF8);

    idle(3);
    check("rst_tdata", td_s | td_w, 64'd0);
    check("rst_tuser", 64'(tu_s | tu_w), 64'd0);
    check("rst_flags", 64'({tv_s, tv_w, tl_s, tl_w, es_s, es_w, sr_s, sr_w}), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // w=9 exp=3, all 0x0FF.
    for (int t = 0; t < 6; t++)
      send(9, mk(9, t == 0, 3, 'h0FF, 'h0FF, 'h0FF, 'h0FF), t == 5, 32'hA000_0000 + 32'(t));
    idle(2);
    // Mixed signs.
    for (int t = 0; t < 6; t++)
      send(9, mk(9, t == 0, 3, 'h100, 'h0FF, 'h001, 'h1FF), t == 5, 32'hB000_0000 + 32'(t));
    // Saturation at exp=8.
    for (int t = 0; t < 6; t++)
      send(9, mk(9, t == 0, 8, 'h0FF, 'h100, 'h001, 'h000), t == 5, 32'hC000_0000 + 32'(t));
    // Uncompressed passthrough.
    for (int t = 0; t < 6; t++)
      send(0, 64'h0123_4567_89AB_CDEF, t == 5, 32'hCAFE_0001);
    idle(1);
    // Two RBs, exponent switch at word 7.
    for (int t = 0; t < 12; t++)
      send(9, mk(9, t % 6 == 0, (t < 6) ? 2 : 5, int'($urandom), int'($urandom),
                 int'($urandom), int'($urandom)), t == 11, $urandom);
    // Short RB, then a fresh exponent tick.
    for (int t = 0; t < 3; t++)
      send(7, mk(7, t == 0, 4, int'($urandom), int'($urandom), int'($urandom), int'($urandom)),
           t == 2, $urandom);
    for (int t = 0; t < 6; t++)
      send(7, mk(7, t == 0, 9, int'($urandom), int'($urandom), int'($urandom), int'($urandom)),
           t == 5, $urandom);
    // Reset mid-RB.
    for (int t = 0; t < 3; t++)
      send(11, mk(11, t == 0, 6, int'($urandom), int'($urandom), int'($urandom), int'($urandom)),
           1'b0, $urandom);
    do_reset(2);
    idle(3);
    for (int t = 0; t < 6; t++)
      send(11, mk(11, t == 0, 1, int'($urandom), int'($urandom), int'($urandom), int'($urandom)),
           t == 5, $urandom);

    // Random packets: any width, any length, random gaps, raw random chunks.
    for (int p = 0; p < 60; p++) begin
      w   = int'($urandom_range(0, 15));
      len = int'($urandom_range(1, 20));
      for (int t = 0; t < len; t++) begin
        send(w, {$urandom, $urandom}, t == len - 1, $urandom);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
      if (p == 30) do_reset(1);
    end

    idle(5);
    check("drain", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
